// File: rtl/hack_mmio_pkg.sv
// hack_mmio_pkg
//   Shared definitions for the Hack data-side MMIO controller:
//   - base addresses of every window in the 15-bit CPU data space
//   - the region-select type used by the address decoder and read path
//   - decode_region(): maps a CPU data address onto its region
package hack_mmio_pkg;

    localparam logic [14:0] RAM_BASE       = 15'h0000;
    localparam logic [14:0] SCREEN_BASE    = 15'h4000;
    localparam logic [14:0] KBD_ADDR       = 15'h6000;
    localparam logic [14:0] KEY_EVENT_ADDR = 15'h6001;
    localparam logic [14:0] LED_ADDR       = 15'h6002;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_SCREEN,
        REG_KBD,
        REG_EVENT,
        REG_LED,
        REG_NONE
    } region_t;

    // RAM is a 16K-aligned window and SCREEN an 8K-aligned window, so each
    // is matched on its upper address bits only.
    function automatic region_t decode_region(input logic [14:0] addr);
        region_t r;
        if ({addr[14], 14'h0000} == RAM_BASE) begin
            r = REG_RAM;
        end else if ({addr[14:13], 13'h0000} == SCREEN_BASE) begin
            r = REG_SCREEN;
        end else if (addr == KBD_ADDR) begin
            r = REG_KBD;
        end else if (addr == KEY_EVENT_ADDR) begin
            r = REG_EVENT;
        end else if (addr == LED_ADDR) begin
            r = REG_LED;
        end else begin
            r = REG_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/hack_mmio_key_debounce.sv
// key_debounce
//   One push-button: two-flop synchroniser, stability counter, accepted
//   level and a one-cycle press-edge pulse.
//   Ports:
//     clk         in   system clock
//     reset_n     in   asynchronous active-low reset
//     key_raw_n   in   raw asynchronous button, active-low
//     pressed     out  accepted (debounced) level, 1 = pressed
//     press_pulse out  high in the cycle whose closing edge accepts a press
module key_debounce
    import hack_mmio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw_n,
    output logic pressed,
    output logic press_pulse
);

    localparam int unsigned     CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_n;
    logic             sync2_n;
    logic             accepted_n;
    logic [CNT_W-1:0] cnt;
    logic             settle;

    // The synchronised level differs from the accepted one and has done so
    // for the full window: the next edge adopts it.
    assign settle = (sync2_n != accepted_n) && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_n    <= 1'b1;
            sync2_n    <= 1'b1;
            accepted_n <= 1'b1;
            cnt        <= '0;
        end else begin
            sync1_n <= key_raw_n;
            sync2_n <= sync1_n;
            if (sync2_n == accepted_n) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                accepted_n <= sync2_n;
                cnt        <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign pressed     = ~accepted_n;
    // Pulse is combinational so the event register sets on the same edge
    // that the accepted level flips to pressed.
    assign press_pulse = settle & ~sync2_n;

endmodule

// File: rtl/hack_mmio.sv
// hack_mmio
//   Memory-mapped I/O controller for the Hack CPU data port.
//   Decodes cpu_addr into RAM / SCREEN / KBD / KEY_EVENT / LED windows,
//   debounces NUM_KEYS buttons into a Hack keyboard code and a sticky
//   write-1-to-clear event register, and holds a writable LED register.
//   Read data has one cycle of latency, matching the block RAMs.
//   Ports:
//     clk, reset_n          clock, asynchronous active-low reset
//     cpu_addr/wdata/we     CPU data port request
//     cpu_rdata             read data, valid the cycle after cpu_addr
//     ram_addr/wdata/we     RAM port (14-bit word address)
//     ram_rdata             RAM read data (1-cycle BRAM)
//     scr_addr/wdata/we     screen buffer port (13-bit word address)
//     scr_rdata             screen read data (1-cycle BRAM)
//     key_raw_n             raw buttons, active-low
//     led_n                 LED drive, active-low
module hack_mmio
    import hack_mmio_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned NUM_LEDS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned KEY_CODE_BASE   = 130
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [14:0]         cpu_addr,
    input  logic [15:0]         cpu_wdata,
    input  logic                cpu_we,
    output logic [15:0]         cpu_rdata,
    output logic [13:0]         ram_addr,
    output logic [15:0]         ram_wdata,
    output logic                ram_we,
    input  logic [15:0]         ram_rdata,
    output logic [12:0]         scr_addr,
    output logic [15:0]         scr_wdata,
    output logic                scr_we,
    input  logic [15:0]         scr_rdata,
    input  logic [NUM_KEYS-1:0] key_raw_n,
    output logic [NUM_LEDS-1:0] led_n
);

    region_t             addr_region;
    region_t             rd_region;
    logic [15:0]         rd_value;
    logic [15:0]         rd_value_next;
    logic [15:0]         kbd_code;
    logic [NUM_KEYS-1:0] key_pressed;
    logic [NUM_KEYS-1:0] key_pulse;
    logic [NUM_KEYS-1:0] key_event;
    logic [NUM_KEYS-1:0] event_clear;
    logic [NUM_LEDS-1:0] led_reg;

    // ------------------------------------------------------------------
    // Address decode and memory pass-through
    // ------------------------------------------------------------------
    assign addr_region = decode_region(cpu_addr);

    assign ram_addr  = cpu_addr[13:0];
    assign ram_wdata = cpu_wdata;
    assign ram_we    = cpu_we && (addr_region == REG_RAM);

    assign scr_addr  = cpu_addr[12:0];
    assign scr_wdata = cpu_wdata;
    assign scr_we    = cpu_we && (addr_region == REG_SCREEN);

    // ------------------------------------------------------------------
    // Push-button debouncers
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .clk         (clk),
            .reset_n     (reset_n),
            .key_raw_n   (key_raw_n[i]),
            .pressed     (key_pressed[i]),
            .press_pulse (key_pulse[i])
        );
    end

    // Lowest-index pressed key wins: scan downwards so the last hit sticks.
    always_comb begin
        kbd_code = '0;
        for (int unsigned i = NUM_KEYS; i > 0; i--) begin
            if (key_pressed[i-1]) begin
                kbd_code = 16'(KEY_CODE_BASE + i - 1);
            end
        end
    end

    // ------------------------------------------------------------------
    // KEY_EVENT: sticky, write-1-to-clear; a press edge beats a clear
    // ------------------------------------------------------------------
    always_comb begin
        event_clear = '0;
        if (cpu_we && (addr_region == REG_EVENT)) begin
            event_clear = cpu_wdata[NUM_KEYS-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_event <= '0;
        end else begin
            key_event <= (key_event & ~event_clear) | key_pulse;
        end
    end

    // ------------------------------------------------------------------
    // LED register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_reg <= '0;
        end else if (cpu_we && (addr_region == REG_LED)) begin
            led_reg <= cpu_wdata[NUM_LEDS-1:0];
        end
    end

    assign led_n = ~led_reg;

    // ------------------------------------------------------------------
    // Read path: register the region and any local register value now,
    // mux with the BRAM outputs next cycle.
    // ------------------------------------------------------------------
    always_comb begin
        rd_value_next = '0;
        case (addr_region)
            REG_KBD:   rd_value_next = kbd_code;
            REG_EVENT: rd_value_next = 16'(key_event);
            REG_LED:   rd_value_next = 16'(led_reg);
            default:   rd_value_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_region <= REG_NONE;
            rd_value  <= '0;
        end else begin
            rd_region <= addr_region;
            rd_value  <= rd_value_next;
        end
    end

    always_comb begin
        cpu_rdata = '0;
        case (rd_region)
            REG_RAM:                    cpu_rdata = ram_rdata;
            REG_SCREEN:                 cpu_rdata = scr_rdata;
            REG_KBD, REG_EVENT, REG_LED: cpu_rdata = rd_value;
            default:                    cpu_rdata = '0;
        endcase
    end

endmodule
